// File: rtl/rf_save_restore.sv
// Context save/restore engine: walks r0..r7 between the register file and a
// single-port memory, spilling to (save) or refilling from (restore) base+2*i.
module rf_save_restore #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] base_addr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       rf_read1regsel,
    output logic [2:0]       rf_read2regsel,
    input  logic [WIDTH-1:0] rf_read1data,
    input  logic [WIDTH-1:0] rf_read2data,
    output logic [2:0]       rf_writeregsel,
    output logic [WIDTH-1:0] rf_writedata,
    output logic             rf_write,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SAVE    = 2'b01,
        S_RESTORE = 2'b10
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] w_base_nxt;
    logic             r_done;
    logic             r_err;
    logic             r_err_pend;
    logic             w_save;
    logic             w_restore;
    logic             w_active;
    logic             w_beat;
    logic             w_last;
    logic             w_err_req;
    logic             w_unused_read2;

    // Reset gates the bus the same cycle so no partial beat escapes.
    assign w_save         = (r_state == S_SAVE) && !rst;
    assign w_restore      = (r_state == S_RESTORE) && !rst;
    assign w_active       = w_save || w_restore;
    assign w_beat         = w_active && mem_ready;
    assign w_last         = w_beat && (r_idx == LAST_IDX);
    assign w_unused_read2 = ^rf_read2data;

    // Next-state, index advance and request rejection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        w_err_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !base_addr[0]) begin
                    w_base_nxt  = base_addr;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = mode ? S_RESTORE : S_SAVE;
                end else begin
                    w_err_req = start;
                end
            end
            S_SAVE, S_RESTORE: begin
                w_err_req = start;
                if (mem_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // State registers; an err colliding with done slips by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_base     <= {WIDTH{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_base     <= w_base_nxt;
            r_done     <= w_last;
            r_err      <= (w_err_req || r_err_pend) && !w_last;
            r_err_pend <= (w_err_req || r_err_pend) && w_last;
        end
    end

    // Register-file and memory port drive; everything idles at zero.
    always_comb begin
        busy           = w_active;
        done           = r_done && !rst;
        err            = r_err && !rst;
        mem_en         = w_active;
        mem_wr         = w_save;
        mem_addr       = w_active ? (r_base + {{(WIDTH-4){1'b0}}, r_idx, 1'b0}) : {WIDTH{1'b0}};
        mem_wr_data    = w_save ? rf_read1data : {WIDTH{1'b0}};
        rf_read1regsel = w_save ? r_idx : 3'd0;
        rf_read2regsel = 3'd0;
        rf_writeregsel = w_restore ? r_idx : 3'd0;
        rf_writedata   = w_restore ? mem_rd_data : {WIDTH{1'b0}};
        rf_write       = w_restore && mem_ready;
    end

endmodule
